pmem_arbiter: RTL and testbench
===============================

# pmem_arbiter

Arbitrates between the instruction cache and data cache 256-bit line ports and serialises the winning request onto the single 64-bit burst memory port. Sits directly downstream of the dcache (and icache) `pmem_*` interfaces, upstream of physical memory. Handles one line transaction at a time: a read fill or a dcache write-back. Each line transfer is exactly four 64-bit beats.

## Interface
- `LINE_BITS`, 256, cache line width.
- `BEAT_BITS`, 64, memory beat width; `LINE_BITS/BEAT_BITS` = 4 beats.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous and active-low.
- `ipmem_address`  in  32  icache line address.
- `ipmem_read`  in  1  icache fill request; held until `ipmem_resp`.
- `ipmem_rdata`  out  256  assembled line to icache.
- `ipmem_resp`  out  1  one-cycle completion pulse to icache.
- `dpmem_address`  in  32  dcache line address.
- `dpmem_read` / `dpmem_write`  in  1 each  dcache fill / write-back request; held until `dpmem_resp`.
- `dpmem_wdata`  in  256  write-back line.
- `dpmem_rdata`  out  256  assembled line to dcache.
- `dpmem_resp`  out  1  one-cycle completion pulse to dcache.
- `bmem_address`  out  32  burst address, bits [4:0] forced to 0.
- `bmem_read` / `bmem_write`  out  1 each  burst command.
- `bmem_wdata`  out  64  current write beat.
- `bmem_rdata`  in  64  current read beat.
- `bmem_resp`  in  1  beat accepted or valid; one pulse per beat.

## Operation
- States: IDLE, RD_BURST, WR_BURST, DONE.
- IDLE: no request pending -> stay.
  - Otherwise pick a winner, latch the address and grant, clear the beat counter.
  - Winner is dcache or icache per the priority rule (see Configuration).
  - `dpmem_write` -> WR_BURST. Any read -> RD_BURST.
- If `dpmem_read` and `dpmem_write` are both high (illegal), the write wins.
- RD_BURST: on each `bmem_resp`, store `bmem_rdata` into line slice [64k+63:64k], where k = beat counter, then increment the counter.
  - On the beat with k=3 -> DONE.
- WR_BURST: `bmem_wdata` = latched line slice k. On each `bmem_resp`, increment k.
  - On the beat with k=3 -> DONE.
- DONE: pulse `resp` to the granted cache for one cycle, then -> IDLE.
  - Read fills also drive the assembled line on that cache's `rdata`.
- Ungranted cache: `resp` stays 0. Its request stays pending and is arbitrated on the next IDLE cycle.
- Beat counter is 2 bits and wraps 3 -> 0 on the final beat.
- The write-back line is latched at grant. Later changes to `dpmem_wdata` are ignored.
- Reset (any state, including mid-burst):
  - State goes to IDLE; counter and grant clear.
  - All outputs go to 0: `bmem_read`, `bmem_write`, `bmem_address`, `bmem_wdata`, both `resp`, both `rdata`.
  - An abandoned burst is not resumed.

## Timing
- All outputs are registered or decoded from registered state; there is no combinational path from the cache ports to `bmem_*`.
- A request sampled in IDLE at cycle N -> `bmem_read`/`bmem_write` and `bmem_address` valid from N+1.
- `bmem_read`/`bmem_write` are held continuously until the 4th `bmem_resp`, then deasserted in DONE.
- Beats need not be back-to-back; gaps without `bmem_resp` hold the counter.
- 4th `bmem_resp` at cycle M -> cache `resp` high in cycle M+1 only.
- Minimum request-to-resp latency: 6 cycles (1 grant + 4 beats + 1 DONE).
- The cache deasserts its request in the cycle after `resp`. The arbiter is in IDLE that cycle and does not re-grant the stale request.
- `*_rdata` holds its value until the next read fill completes.

## Configuration
- `PMEM_ARB_ROUND_ROBIN_EN` undefined: fixed priority, dcache always wins when both caches request in the same IDLE cycle.
- `PMEM_ARB_ROUND_ROBIN_EN` defined:
  - A 1-bit last-grant register (reset: icache) is kept.
  - On a simultaneous request, the cache not granted last wins.
  - Single requests are granted regardless of the register.

## Structure
- Shared package `pmem_arb_pkg`:
  - state enum `pmem_arb_state_t`
  - grant enum `pmem_grant_t` {GRANT_I, GRANT_D}
  - constants `LINE_BITS`, `BEAT_BITS`, `NUM_BEATS`
- Sub-module `line_burst_adaptor`:
  - Owns the beat counter, line assembly register and write beat mux.
  - Signals the last beat to the arbiter FSM.

## Test plan
- icache read 0x0000_1234, memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 -> `bmem_address`=0x0000_1220; `ipmem_rdata`={0x44..44,0x33..33,0x22..22,0x11..11}; `ipmem_resp` one cycle after 4th beat.
- dcache write 0x8000_0040, wdata bytes 0x00..0x1F -> `bmem_wdata` beats 0x0706050403020100 … 0x1F1E1D1C1B1A1918 in order; one `dpmem_resp`; `ipmem_resp` stays 0.
- icache and dcache reads asserted same cycle -> dcache served first, icache served next; without the macro dcache wins every tie; with the macro, a repeated tie alternates D, I, D.
- Read burst with 3 idle cycles between beats 1 and 2 -> line assembled correctly; `resp` 9 cycles after the request.
- `rst` asserted after 2 beats of a write -> `bmem_write`=0 and both `resp`=0 immediately; after release, a pending request restarts from beat 0.

Source files
------------

// File: rtl/pmem_arb_pkg.sv
// Shared types and constants for the pmem line arbiter.
// Optional round-robin tie-breaking is selected with PMEM_ARB_ROUND_ROBIN_EN.
package pmem_arb_pkg;

  localparam int LINE_BITS = 256;
  localparam int BEAT_BITS = 64;
  localparam int NUM_BEATS = LINE_BITS / BEAT_BITS;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2,
    DONE     = 2'd3
  } pmem_arb_state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } pmem_grant_t;

endpackage

// File: rtl/line_burst_adaptor.sv
// Beat counter, line assembly/write-back register and write beat mux.
// One 256-bit line is moved as four 64-bit beats, lowest slice first.
module line_burst_adaptor
  import pmem_arb_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 load_line,
  input  logic [LINE_BITS-1:0] load_data,
  input  logic                 beat,
  input  logic                 rd_mode,
  input  logic [BEAT_BITS-1:0] beat_rdata,
  output logic                 last_beat,
  output logic [LINE_BITS-1:0] fill_line,
  output logic [BEAT_BITS-1:0] beat_wdata
);

  logic [1:0]           cnt_q;
  logic [LINE_BITS-1:0] line_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      line_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
      if (load_line) line_q <= load_data;
    end else if (beat) begin
      cnt_q <= cnt_q + 2'd1;
      if (rd_mode) line_q[{cnt_q, 6'd0} +: BEAT_BITS] <= beat_rdata;
    end
  end

  assign last_beat  = beat && (cnt_q == 2'(NUM_BEATS - 1));
  // Complete line including the final beat, so it can be captured on that edge.
  assign fill_line  = {beat_rdata, line_q[LINE_BITS-BEAT_BITS-1:0]};
  assign beat_wdata = line_q[{cnt_q, 6'd0} +: BEAT_BITS];

endmodule

// File: rtl/pmem_arbiter.sv
// Arbitrates icache/dcache line requests onto a single 64-bit burst port.
// Define PMEM_ARB_ROUND_ROBIN_EN for round-robin ties; default is dcache priority.
module pmem_arbiter
  import pmem_arb_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          ipmem_address,
  input  logic                 ipmem_read,
  output logic [LINE_BITS-1:0] ipmem_rdata,
  output logic                 ipmem_resp,
  input  logic [31:0]          dpmem_address,
  input  logic                 dpmem_read,
  input  logic                 dpmem_write,
  input  logic [LINE_BITS-1:0] dpmem_wdata,
  output logic [LINE_BITS-1:0] dpmem_rdata,
  output logic                 dpmem_resp,
  output logic [31:0]          bmem_address,
  output logic                 bmem_read,
  output logic                 bmem_write,
  output logic [BEAT_BITS-1:0] bmem_wdata,
  input  logic [BEAT_BITS-1:0] bmem_rdata,
  input  logic                 bmem_resp,
  output logic [1:0]           dbg_state
);

  // Burst port: bmem_read/bmem_write are held from grant until the 4th
  // bmem_resp; each bmem_resp cycle transfers exactly one beat.

  pmem_arb_state_t      state_q, state_d;
  pmem_grant_t          grant_q;
  logic [31:0]          addr_q;
  logic [LINE_BITS-1:0] irdata_q, drdata_q;

  logic                 d_req, i_req, pick_d, start, load_line;
  logic                 beat, last_beat;
  logic [31:0]          sel_addr;
  logic [LINE_BITS-1:0] fill_line;
  logic [BEAT_BITS-1:0] beat_wdata;

  assign d_req = dpmem_read | dpmem_write;
  assign i_req = ipmem_read;

`ifdef PMEM_ARB_ROUND_ROBIN_EN
  // grant_q doubles as the last-grant register; it resets to icache.
  assign pick_d = d_req && (!i_req || (grant_q == GRANT_I));
`else
  assign pick_d = d_req;
`endif

  assign sel_addr = pick_d ? dpmem_address : ipmem_address;

  always_comb begin
    state_d   = state_q;
    start     = 1'b0;
    load_line = 1'b0;
    case (state_q)
      IDLE: begin
        if (d_req || i_req) begin
          start = 1'b1;
          if (pick_d && dpmem_write) begin
            load_line = 1'b1;
            state_d   = WR_BURST;
          end else begin
            state_d = RD_BURST;
          end
        end
      end
      RD_BURST, WR_BURST: if (last_beat) state_d = DONE;
      DONE:               state_d = IDLE;
      default:            state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_q <= GRANT_I;
      addr_q  <= '0;
    end else if (start) begin
      grant_q <= pick_d ? GRANT_D : GRANT_I;
      addr_q  <= sel_addr & ~32'h0000_001F;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irdata_q <= '0;
      drdata_q <= '0;
    end else if (last_beat && (state_q == RD_BURST)) begin
      if (grant_q == GRANT_D) drdata_q <= fill_line;
      else                    irdata_q <= fill_line;
    end
  end

  assign beat = bmem_resp && ((state_q == RD_BURST) || (state_q == WR_BURST));

  line_burst_adaptor u_adaptor (
    .clk        (clk),
    .rst        (rst),
    .clear      (start),
    .load_line  (load_line),
    .load_data  (dpmem_wdata),
    .beat       (beat),
    .rd_mode    (state_q == RD_BURST),
    .beat_rdata (bmem_rdata),
    .last_beat  (last_beat),
    .fill_line  (fill_line),
    .beat_wdata (beat_wdata)
  );

  assign bmem_address = addr_q;
  assign bmem_read    = (state_q == RD_BURST);
  assign bmem_write   = (state_q == WR_BURST);
  assign bmem_wdata   = (state_q == WR_BURST) ? beat_wdata : '0;
  assign ipmem_resp   = (state_q == DONE) && (grant_q == GRANT_I);
  assign dpmem_resp   = (state_q == DONE) && (grant_q == GRANT_D);
  assign ipmem_rdata  = irdata_q;
  assign dpmem_rdata  = drdata_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed self-checking bench for pmem_arbiter with a small burst-memory responder.
module tb_pmem_arbiter;
  import pmem_arb_pkg::*;

  logic                 clk, rst;
  logic [31:0]          ipmem_address, dpmem_address;
  logic                 ipmem_read, dpmem_read, dpmem_write;
  logic [LINE_BITS-1:0] ipmem_rdata, dpmem_rdata, dpmem_wdata;
  logic                 ipmem_resp, dpmem_resp;
  logic [31:0]          bmem_address;
  logic                 bmem_read, bmem_write, bmem_resp;
  logic [BEAT_BITS-1:0] bmem_wdata, bmem_rdata;
  logic [1:0]           dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [BEAT_BITS-1:0] exp_q[$];

  pmem_arbiter dut (
    .clk(clk), .rst(rst),
    .ipmem_address(ipmem_address), .ipmem_read(ipmem_read),
    .ipmem_rdata(ipmem_rdata), .ipmem_resp(ipmem_resp),
    .dpmem_address(dpmem_address), .dpmem_read(dpmem_read), .dpmem_write(dpmem_write),
    .dpmem_wdata(dpmem_wdata), .dpmem_rdata(dpmem_rdata), .dpmem_resp(dpmem_resp),
    .bmem_address(bmem_address), .bmem_read(bmem_read), .bmem_write(bmem_write),
    .bmem_wdata(bmem_wdata), .bmem_rdata(bmem_rdata), .bmem_resp(bmem_resp),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, act, exp);
    end
  endtask

  // driver tasks
  task automatic wait_cmd(input bit want_write, input string tag);
    int n = 0;
    while (((want_write ? bmem_write : bmem_read) !== 1'b1) && (n < 20)) begin
      tick();
      n++;
    end
    check({tag, "_start"}, 256'(want_write ? bmem_write : bmem_read), 256'd1);
  endtask

  // Returns in the cycle after the 4th beat (expected DONE cycle).
  task automatic serve_read(input logic [255:0] line, input int gap_after,
                            input int gap_len, input string tag);
    wait_cmd(1'b0, tag);
    for (int k = 0; k < 4; k++) begin
      bmem_resp  = 1'b1;
      bmem_rdata = line[k*64 +: 64];
      tick();
      bmem_resp  = 1'b0;
      bmem_rdata = '0;
      if (k == gap_after) begin
        repeat (gap_len) tick();
        check({tag, "_hold"}, 256'(bmem_read), 256'd1);
      end
    end
  endtask

  task automatic serve_write(input logic [255:0] line, input int nbeats, input string tag);
    wait_cmd(1'b1, tag);
    for (int k = 0; k < 4; k++) exp_q.push_back(line[k*64 +: 64]);
    for (int k = 0; k < nbeats; k++) begin
      logic [63:0] e;
      e = exp_q.pop_front();
      check($sformatf("%s_wdata%0d", tag, k), 256'(bmem_wdata), 256'(e));
      bmem_resp = 1'b1;
      tick();
      bmem_resp = 1'b0;
    end
    exp_q.delete();
  endtask

  logic [255:0] line_a, line_b, line_c, line_d, wline, wline2, exp_irdata;
  int t_req;
  bit first_d;

  initial begin
    line_a = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
              64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    line_b = {64'hB3B3_0000_0000_0003, 64'hB2B2_0000_0000_0002,
              64'hB1B1_0000_0000_0001, 64'hB0B0_0000_0000_0000};
    line_c = {64'hC3C3_1234_5678_9ABC, 64'hC2C2_0F0F_0F0F_0F0F,
              64'hC1C1_F0F0_F0F0_F0F0, 64'hC0C0_DEAD_BEEF_0000};
    line_d = {64'hD3D3_D3D3_D3D3_D3D3, 64'hD2D2_D2D2_D2D2_D2D2,
              64'hD1D1_D1D1_D1D1_D1D1, 64'hD0D0_D0D0_D0D0_D0D0};
    for (int i = 0; i < 32; i++) begin
      wline[i*8 +: 8]  = 8'(i);
      wline2[i*8 +: 8] = 8'(8'hA0 + i);
    end

    rst = 1'b0;
    ipmem_address = '0; ipmem_read = 1'b0;
    dpmem_address = '0; dpmem_read = 1'b0; dpmem_write = 1'b0; dpmem_wdata = '0;
    bmem_resp = 1'b0; bmem_rdata = '0;
    repeat (2) tick();

    // reset state
    check("rst_state", 256'(dbg_state), 256'(IDLE));
    check("rst_bmem_rd", 256'(bmem_read), 256'd0);
    check("rst_bmem_wr", 256'(bmem_write), 256'd0);
    check("rst_bmem_addr", 256'(bmem_address), 256'd0);
    check("rst_resps", 256'({ipmem_resp, dpmem_resp}), 256'd0);
    check("rst_irdata", ipmem_rdata, 256'd0);
    rst = 1'b1;
    tick();

    // icache read, back-to-back beats
    ipmem_address = 32'h0000_1234;
    ipmem_read = 1'b1;
    t_req = cyc;
    tick();
    check("ird_addr", 256'(bmem_address), 256'h0000_1220);
    check("ird_no_write", 256'(bmem_write), 256'd0);
    serve_read(line_a, -1, 0, "ird");
    check("ird_resp", 256'(ipmem_resp), 256'd1);
    check("ird_dresp", 256'(dpmem_resp), 256'd0);
    check("ird_rdata", ipmem_rdata, line_a);
    check("ird_rd_drop", 256'(bmem_read), 256'd0);
    check("ird_latency", 256'(cyc - t_req + 1), 256'd6);
    ipmem_read = 1'b0;
    tick();
    check("ird_resp_once", 256'(ipmem_resp), 256'd0);
    check("ird_idle", 256'(dbg_state), 256'(IDLE));
    tick();
    check("ird_no_regrant", 256'(bmem_read), 256'd0);
    exp_irdata = line_a;

    // dcache write-back; wdata changes after grant must be ignored
    dpmem_address = 32'h8000_0040;
    dpmem_wdata = wline;
    dpmem_write = 1'b1;
    tick();
    check("dwr_addr", 256'(bmem_address), 256'h8000_0040);
    check("dwr_no_read", 256'(bmem_read), 256'd0);
    dpmem_wdata = ~wline;
    serve_write(wline, 4, "dwr");
    check("dwr_resp", 256'(dpmem_resp), 256'd1);
    check("dwr_iresp", 256'(ipmem_resp), 256'd0);
    check("dwr_wr_drop", 256'(bmem_write), 256'd0);
    dpmem_write = 1'b0;
    tick();
    check("dwr_resp_once", 256'(dpmem_resp), 256'd0);

    // simultaneous reads; the previous grant was dcache
`ifdef PMEM_ARB_ROUND_ROBIN_EN
    first_d = 1'b0;
`else
    first_d = 1'b1;
`endif
    ipmem_address = 32'h0000_0100;
    dpmem_address = 32'h0000_0200;
    ipmem_read = 1'b1;
    dpmem_read = 1'b1;
    tick();
    check("tie1_addr", 256'(bmem_address), first_d ? 256'h200 : 256'h100);
    serve_read(line_b, -1, 0, "tie1");
    check("tie1_resp", 256'({dpmem_resp, ipmem_resp}), first_d ? 256'd2 : 256'd1);
    check("tie1_rdata", first_d ? dpmem_rdata : ipmem_rdata, line_b);
    if (first_d) dpmem_read = 1'b0; else ipmem_read = 1'b0;
    tick();
    serve_read(line_c, -1, 0, "tie2");
    check("tie2_addr", 256'(bmem_address), first_d ? 256'h100 : 256'h200);
    check("tie2_resp", 256'({dpmem_resp, ipmem_resp}), first_d ? 256'd1 : 256'd2);
    check("tie2_rdata", first_d ? ipmem_rdata : dpmem_rdata, line_c);
    exp_irdata = first_d ? line_c : line_b;
    ipmem_read = 1'b0;
    dpmem_read = 1'b0;
    tick();

    // dcache read with 3 idle cycles between beats 1 and 2
    dpmem_address = 32'h0000_0ABC;
    dpmem_read = 1'b1;
    t_req = cyc;
    tick();
    check("gap_addr", 256'(bmem_address), 256'h0000_0AA0);
    serve_read(line_d, 1, 3, "gap");
    check("gap_resp", 256'(dpmem_resp), 256'd1);
    check("gap_rdata", dpmem_rdata, line_d);
    check("gap_latency", 256'(cyc - t_req + 1), 256'd9);
    check("gap_irdata_held", ipmem_rdata, exp_irdata);
    dpmem_read = 1'b0;
    tick();

    // reset in the middle of a write burst
    dpmem_address = 32'h0000_0040;
    dpmem_wdata = wline2;
    dpmem_write = 1'b1;
    tick();
    serve_write(wline2, 2, "prerst");
    #2 rst = 1'b0;
    #1;
    check("mrst_bmem_wr", 256'(bmem_write), 256'd0);
    check("mrst_resps", 256'({ipmem_resp, dpmem_resp}), 256'd0);
    check("mrst_state", 256'(dbg_state), 256'(IDLE));
    check("mrst_addr", 256'(bmem_address), 256'd0);
    check("mrst_wdata", 256'(bmem_wdata), 256'd0);
    check("mrst_drdata", dpmem_rdata, 256'd0);
    tick();
    rst = 1'b1;
    serve_write(wline2, 4, "restart");
    check("restart_resp", 256'(dpmem_resp), 256'd1);
    check("restart_addr", 256'(bmem_address), 256'h0000_0040);
    dpmem_write = 1'b0;
    tick();
    check("restart_idle", 256'(dbg_state), 256'(IDLE));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
